// File: rtl/adder_nibble_seq.sv
// adder_nibble_seq: runs a 4*NIBBLES-bit add through one shared clocked 4-bit adder slice,
// least-significant nibble first, holding each nibble SETTLE cycles before sampling.
module adder_nibble_seq #(
    parameter int NIBBLES = 4,
    parameter int SETTLE  = 4
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [4*NIBBLES-1:0] OP_A,
    input  logic [4*NIBBLES-1:0] OP_B,
    input  logic                 CIN,
    output logic                 READY,
    output logic                 DONE,
    output logic [4*NIBBLES-1:0] RESULT,
    output logic                 COUT,
    output logic [3:0]           ADD_A,
    output logic [3:0]           ADD_B,
    output logic                 ADD_CIN,
    input  logic [3:0]           ADD_SUM,
    input  logic                 ADD_COUT
);
    localparam int W  = 4 * NIBBLES;
    localparam int NW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state, state_n;
    logic [W-1:0]  opa, opb;
    logic          cin_r, carry_r;
    logic [NW-1:0] nib;
    logic [3:0]    cnt;
    logic          sample, last;

    assign sample = state == S_RUN && cnt == 4'(SETTLE - 1);
    assign last   = nib == NW'(NIBBLES - 1);

    // Slice drive depends on registered state only, so no loop forms through the slice.
    always_comb begin
        state_n = state;
        READY   = state == S_IDLE;
        DONE    = state == S_DONE;
        ADD_A   = '0;
        ADD_B   = '0;
        ADD_CIN = 1'b0;
        case (state)
            S_IDLE: state_n = START ? S_RUN : S_IDLE;
            S_RUN: begin
                state_n = sample && last ? S_DONE : S_RUN;
                ADD_A   = opa[{nib, 2'b00} +: 4];
                ADD_B   = opb[{nib, 2'b00} +: 4];
                ADD_CIN = nib == '0 ? cin_r : carry_r;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RST) begin
            state   <= S_IDLE;
            opa     <= '0;
            opb     <= '0;
            cin_r   <= 1'b0;
            carry_r <= 1'b0;
            nib     <= '0;
            cnt     <= '0;
            RESULT  <= '0;
            COUT    <= 1'b0;
        end else begin
            state <= state_n;
            if (READY && START) begin
                opa    <= OP_A;
                opb    <= OP_B;
                cin_r  <= CIN;
                RESULT <= '0;
                COUT   <= 1'b0;
                nib    <= '0;
                cnt    <= '0;
            end else if (state == S_RUN) begin
                cnt <= sample ? 4'd0 : cnt + 4'd1;
                if (sample) begin
                    RESULT[{nib, 2'b00} +: 4] <= ADD_SUM;
                    carry_r                   <= ADD_COUT;
                    if (last)
                        COUT <= ADD_COUT;
                    else
                        nib <= nib + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_nibble_seq.sv
// tb_adder_nibble_seq: directed vectors with a scoreboard; main DUT drives a clocked ripple slice,
// a second NIBBLES=2/SETTLE=1 instance drives an ideal combinational adder.
module tb_adder_nibble_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, cin, start2, cin2;
    logic [15:0] op_a, op_b, result;
    logic [7:0]  op_a2, op_b2, result2;
    logic        ready, done, cout, ready2, done2, cout2;
    logic [3:0]  add_a, add_b, add_sum, add_a2, add_b2, add_sum2;
    logic        add_cin, add_cout, add_cin2, add_cout2;
    logic [2:0]  cr;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [16:0] exp_q[$];
    logic [8:0]  exp2_q[$];
    int          acc_q[$];
    int          acc2_q[$];
    logic [16:0] e1;
    logic [8:0]  e2;
    int          a1, a2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_nibble_seq u_dut (
        .CK(clk), .RST(rst_n), .START(start), .OP_A(op_a), .OP_B(op_b), .CIN(cin),
        .READY(ready), .DONE(done), .RESULT(result), .COUT(cout),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin), .ADD_SUM(add_sum), .ADD_COUT(add_cout)
    );

    adder_nibble_seq #(.NIBBLES(2), .SETTLE(1)) u_dut2 (
        .CK(clk), .RST(rst_n), .START(start2), .OP_A(op_a2), .OP_B(op_b2), .CIN(cin2),
        .READY(ready2), .DONE(done2), .RESULT(result2), .COUT(cout2),
        .ADD_A(add_a2), .ADD_B(add_b2), .ADD_CIN(add_cin2), .ADD_SUM(add_sum2), .ADD_COUT(add_cout2)
    );

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Clocked ripple slice: internal carries are registered, so a new nibble needs 3 edges to settle.
    always @(posedge clk) begin
        cr[0] <= maj(add_a[0], add_b[0], add_cin);
        cr[1] <= maj(add_a[1], add_b[1], cr[0]);
        cr[2] <= maj(add_a[2], add_b[2], cr[1]);
    end
    assign add_sum  = {add_a[3] ^ add_b[3] ^ cr[2], add_a[2] ^ add_b[2] ^ cr[1],
                       add_a[1] ^ add_b[1] ^ cr[0], add_a[0] ^ add_b[0] ^ add_cin};
    assign add_cout = maj(add_a[3], add_b[3], cr[2]);
    assign {add_cout2, add_sum2} = add_a2 + add_b2 + add_cin2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: records acceptances and checks every DONE against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && start && ready) acc_q.push_back(cyc + 1);
        if (rst_n && start2 && ready2) acc2_q.push_back(cyc + 1);
        if (done) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) check("unexpected_done", done, 1'b0);
            else begin
                e1 = exp_q.pop_front();
                a1 = acc_q.pop_front();
                check("result", result, e1[15:0]);
                check("cout", cout, e1[16]);
                check("latency", cyc - a1, 16);
            end
        end
        if (done2) begin
            if (exp2_q.size() == 0 || acc2_q.size() == 0) check("unexpected_done2", done2, 1'b0);
            else begin
                e2 = exp2_q.pop_front();
                a2 = acc2_q.pop_front();
                check("result2", result2, e2[7:0]);
                check("cout2", cout2, e2[8]);
                check("latency2", cyc - a2, 2);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [16:0] e, input bit push, input bit hold);
        int n = 0;
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        if (push) exp_q.push_back(e);
        while (!ready && n < 100) begin step(1); n++; end
        if (n >= 100) check("ready_timeout", ready, 1'b1);
        step(1);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int which);
        int n = 0;
        while (!(which == 1 ? done : done2) && n < 200) begin step(1); n++; end
        if (n >= 200) check("done_timeout", which == 1 ? done : done2, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; cin = 1'b0; cin2 = 1'b0;
        op_a = '0; op_b = '0; op_a2 = '0; op_b2 = '0;
        step(5);
        rst_n = 1'b1;
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 16'h0);
        check("rst_cout", cout, 1'b0);
        check("rst_add_a", add_a, 4'h0);
        check("rst_add_b", add_b, 4'h0);
        check("rst_add_cin", add_cin, 1'b0);
        step(2);

        // Full carry ripple: carry must chain through every nibble.
        issue(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000}, 1, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_add_a_n%0d", k), add_a, 4'hF);
            check($sformatf("t1_add_b_n%0d", k), add_b, k == 0 ? 4'h1 : 4'h0);
            check($sformatf("t1_add_cin_n%0d", k), add_cin, k == 0 ? 1'b0 : 1'b1);
            check($sformatf("t1_ready_n%0d", k), ready, 1'b0);
            step(4);
        end
        check("t1_done_at_16", done, 1'b1);
        step(2);

        issue(16'h1234, 16'h4321, 1'b1, {1'b0, 16'h5556}, 1, 0);
        wait_done(1);
        step(5);
        check("t2_hold_result", result, 16'h5556);
        check("t2_hold_cout", cout, 1'b0);
        check("t2_idle_ready", ready, 1'b1);
        check("t2_idle_add_a", add_a, 4'h0);

        // Back-to-back with START held; operands changed mid-RUN form the second request.
        issue(16'h00FF, 16'h0001, 1'b0, {1'b0, 16'h0100}, 1, 1);
        op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b1;
        exp_q.push_back({1'b0, 16'h1011});
        wait_done(1);
        step(1);
        check("b2b_ready_after_done", ready, 1'b1);
        step(1);
        check("b2b_second_accept", ready, 1'b0);
        check("b2b_nib0_a", add_a, 4'hF);
        start = 1'b0;
        wait_done(1);
        step(3);

        // Reset at cycle 7 of a RUN abandons the operation.
        issue(16'h1111, 16'h2222, 1'b0, '0, 0, 0);
        step(6);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        acc_q.delete();
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_result", result, 16'h0);
        check("mid_rst_cout", cout, 1'b0);
        check("mid_rst_add_a", add_a, 4'h0);
        check("mid_rst_add_b", add_b, 4'h0);
        check("mid_rst_add_cin", add_cin, 1'b0);
        step(20);
        check("mid_rst_still_idle", ready, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000}, 1, 0);
        wait_done(1);
        step(2);

        // START toggled throughout RUN must be ignored.
        issue(16'h0F0F, 16'h00F1, 1'b0, {1'b0, 16'h1000}, 1, 0);
        for (int i = 0; i < 15; i++) begin
            start = i[0];
            op_a  = 16'(i * 16'h1111);
            step(1);
        end
        start = 1'b0;
        wait_done(1);
        step(10);
        check("ign_ready", ready, 1'b1);
        check("ign_result_held", result, 16'h1000);

        op_a2 = 8'hAB; op_b2 = 8'h56; cin2 = 1'b1; start2 = 1'b1;
        exp2_q.push_back({1'b1, 8'h02});
        step(1);
        start2 = 1'b0;
        wait_done(2);
        step(2);
        op_a2 = 8'h0F; op_b2 = 8'h01; cin2 = 1'b0; start2 = 1'b1;
        exp2_q.push_back({1'b0, 8'h10});
        step(1);
        start2 = 1'b0;
        wait_done(2);
        step(3);

        check("scoreboard_empty", exp_q.size(), 0);
        check("scoreboard2_empty", exp2_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/adder_nibble_seq.md
# adder_nibble_seq

Sequencing controller that performs a 4·NIBBLES-bit addition by time-multiplexing one external 4-bit clocked ripple-adder slice, least-significant nibble first.

- Operands are presented one nibble per step, with the carry chained through a controller register.
- Each nibble is held for SETTLE cycles so the slice's internally registered carries settle before SUM/COUT are sampled.
- The block sits between a request source (valid/ready style START/READY) and the shared 4-bit adder datapath.

## Interface
Parameters:
- NIBBLES, default 4: operand width in nibbles (operand width W = 4·NIBBLES); legal range 1..8.
- SETTLE, default 4: cycles each nibble is held before sampling; legal range 1..15. 4 covers a 4-bit slice with 3 registered internal carries.

Ports:
- CK  in  1  clock; all logic rising-edge.
- RST  in  1  reset; synchronous, active-low.
- START  in  1  request; accepted only on an edge where START=1 and READY=1.
- OP_A  in  W  operand A; sampled on acceptance.
- OP_B  in  W  operand B; sampled on acceptance.
- CIN  in  1  carry-in; sampled on acceptance.
- READY  out  1  high only in IDLE.
- DONE  out  1  one-cycle pulse; RESULT/COUT valid.
- RESULT  out  W  sum.
- COUT  out  1  final carry-out.
- ADD_A  out  4  nibble of A to the slice.
- ADD_B  out  4  nibble of B to the slice.
- ADD_CIN  out  1  carry into the slice.
- ADD_SUM  in  4  slice sum.
- ADD_COUT  in  1  slice carry-out.

## Operation
- States: IDLE, RUN, DONE.
- Registers: opa, opb (W bits), cin_r, nib counter (ceil(log2 NIBBLES) bits, min 1), cnt counter (4 bits), carry_r.

IDLE:
- READY=1.
- On START: latch OP_A/OP_B/CIN, clear RESULT and COUT, set nib=0, cnt=0, go to RUN.
- Without START: stay in IDLE.

RUN:
- Slice drive:
  - ADD_A = opa[4·nib+3:4·nib].
  - ADD_B = opb[4·nib+3:4·nib].
  - ADD_CIN = cin_r when nib=0, else carry_r.
- Each edge with cnt < SETTLE−1: cnt increments.
- Edge with cnt = SETTLE−1:
  - RESULT[4·nib+3:4·nib] ← ADD_SUM.
  - carry_r ← ADD_COUT.
  - cnt ← 0.
  - If nib = NIBBLES−1: COUT ← ADD_COUT and go to DONE. Otherwise nib increments.

DONE:
- DONE=1 for exactly this one cycle.
- Next edge returns to IDLE unconditionally.

Outside RUN:
- ADD_A=0, ADD_B=0, ADD_CIN=0.

Rules:
- START while READY=0 is ignored; no queuing.
- OP_A/OP_B/CIN changes after acceptance have no effect.
- RESULT and COUT hold their final values through DONE and IDLE until the next acceptance clears them.
- During RUN, RESULT holds partial nibbles and is not valid.
- Arithmetic: {COUT, RESULT} = OP_A + OP_B + CIN, exact in W+1 bits. No overflow flag.
- Reset (RST=0 at an edge) from any state, including mid-RUN:
  - state=IDLE, READY=1, DONE=0, RESULT=0, COUT=0.
  - opa, opb, cin_r, carry_r, nib, cnt all 0.
  - The operation in flight is abandoned with no DONE.
  - RST=0 overrides a simultaneous START.

## Timing
- Acceptance at edge E0.
- Slice inputs for nibble k are stable from the cycle after edge E0+k·SETTLE, through edge E0+(k+1)·SETTLE, where they are sampled.
- Final sample at edge E0+NIBBLES·SETTLE. DONE is high in the following cycle.
- Latency from accepting edge to DONE-high cycle: NIBBLES·SETTLE cycles (16 at defaults).
- READY returns high one cycle after DONE. Earliest next acceptance is edge E0+NIBBLES·SETTLE+2.
- Outputs are registered except ADD_A/ADD_B/ADD_CIN, which are decoded combinationally from registered state only. There is no path from ADD_SUM/ADD_COUT to ADD_*, so no combinational loop exists through the slice.
- Sampling exactly on cnt = SETTLE−1 is mandatory. Sampling earlier reads an unsettled slice.

## Test plan
Bench setup: defaults unless stated; slice is the team's 4-bit clocked ripple adder with its RST tied inactive.

- OP_A=0xFFFF, OP_B=0x0001, CIN=0 → RESULT=0x0000, COUT=1; DONE exactly 16 cycles after acceptance; ADD_CIN=1 during nibbles 1–3.
- OP_A=0x1234, OP_B=0x4321, CIN=1 → RESULT=0x5556, COUT=0. Then RESULT stays held through IDLE until the next START.
- Back-to-back: START held high continuously. Second acceptance occurs exactly 2 cycles after the first DONE. OP_A/OP_B changed mid-RUN do not alter the first result (0x00FF+0x0001 → 0x0100).
- RST=0 for one edge at cycle 7 of a RUN → no DONE; READY=1, RESULT=0, ADD_*=0 next cycle. A new add 0x8000+0x8000 → RESULT=0x0000, COUT=1.
- START pulsed while READY=0 (every RUN cycle) → ignored. Exactly one DONE per accepted request.
- SETTLE=1, NIBBLES=2, with an ideal combinational adder model: 0xAB+0x56+CIN=1 → RESULT=0x02, COUT=1; DONE 2 cycles after acceptance.
